// File: rtl/stage_4_carry_resolver_pkg.sv
// Shared encodings for the carry resolver stage:
// FSM states and the input word-count flag.
package stage_4_carry_resolver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PROC2,
    EMIT_HOLD,
    EMIT_RUN,
    FLUSH_HOLD,
    FLUSH_RUN
  } state_t;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_ONE  = 2'b01;
  localparam logic [1:0] FLAG_BAD  = 2'b10;
  localparam logic [1:0] FLAG_TWO  = 2'b11;

endpackage

// File: rtl/stage_4_carry_resolver.sv
// Resolves carries out of a byte stream: a held byte plus a run
// of pending all-ones bytes absorbs late carries before emission.
module stage_4_carry_resolver
  import stage_4_carry_resolver_pkg::*;
#(
  parameter int OUTPUT_DATA_WIDTH = 8,
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int RUN_COUNT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  flag,
  input  logic                        flag_final_bits,
  input  logic [INPUT_DATA_WIDTH-1:0] in_bitstream_1,
  input  logic [INPUT_DATA_WIDTH-1:0] in_bitstream_2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0] out_byte,
  output logic                        out_last,
  output logic                        error
);

  localparam int B  = OUTPUT_DATA_WIDTH;
  localparam int IW = INPUT_DATA_WIDTH;
  localparam int RW = RUN_COUNT_WIDTH;
  localparam int CW = IW - B;

  typedef struct packed {
    logic [B-1:0]  h;
    logic          hv;
    logic [RW-1:0] r;
    logic          emit;
    logic [B-1:0]  e;
    logic [RW-1:0] n;
    logic [B-1:0]  fill;
    logic          err;
  } res_t;

  // One word: carry step, then byte step, merged into a single
  // emission of e followed by n copies of fill.
  function automatic res_t resolve(
    input logic [B-1:0]  h,
    input logic          hv,
    input logic [RW-1:0] r,
    input logic [IW-1:0] w
  );
    res_t o;
    logic [CW-1:0] c;
    logic [B-1:0] b;
    logic cemit;
    o = '0;
    o.h = h;
    o.hv = hv;
    o.r = r;
    c = w[IW-1:B];
    b = w[B-1:0];
    cemit = 1'b0;
    if (c > CW'(1)) o.err = 1'b1;
    if (|c) begin
      if (|r) begin
        cemit = 1'b1;
        o.e = h + 1'b1;
        o.n = r - 1'b1;
        o.fill = '0;
        o.h = '0;
        o.r = '0;
      end else begin
        if (&h || !hv) o.err = 1'b1;
        o.h = h + 1'b1;
      end
    end
    if (!o.hv) begin
      o.h = b;
      o.hv = 1'b1;
    end else if (&b) begin
      if (&o.r) o.err = 1'b1;
      else o.r = o.r + 1'b1;
    end else begin
      // a zeroed hold simply extends the zero run
      if (cemit) begin
        o.n = o.n + 1'b1;
      end else begin
        o.e = o.h;
        o.n = o.r;
        o.fill = '1;
      end
      o.emit = 1'b1;
      o.h = b;
      o.r = '0;
    end
    o.emit = o.emit | cemit;
    return o;
  endfunction

  state_t state, state_nxt;
  logic [B-1:0]  hold_q, hold_nxt;
  logic          hv_q, hv_nxt;
  logic [RW-1:0] run_q, run_nxt;
  logic [RW-1:0] cnt_q, cnt_nxt;
  logic [B-1:0]  ob_q, ob_nxt;
  logic [B-1:0]  fill_q, fill_nxt;
  logic          last_q, last_nxt;
  logic          err_q, err_nxt;
  logic [IW-1:0] w2_q, w2_nxt;
  logic          pw2_q, pw2_nxt;
  logic          pfl_q, pfl_nxt;
  logic          armed_q;
  logic          take, advance;
  logic [IW-1:0] word;
  res_t          res;

  assign in_ready  = armed_q && (state == IDLE);
  assign out_valid = (state == EMIT_HOLD) || (state == EMIT_RUN)
                  || (state == FLUSH_HOLD) || (state == FLUSH_RUN);
  assign out_byte  = ob_q;
  assign out_last  = last_q;
  assign error     = err_q;

  assign word = (state == PROC2) ? w2_q : in_bitstream_1;
  assign res  = resolve(hold_q, hv_q, run_q, word);

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    hv_nxt    = hv_q;
    run_nxt   = run_q;
    cnt_nxt   = cnt_q;
    ob_nxt    = ob_q;
    fill_nxt  = fill_q;
    last_nxt  = last_q;
    err_nxt   = err_q;
    w2_nxt    = w2_q;
    pw2_nxt   = pw2_q;
    pfl_nxt   = pfl_q;
    take      = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w2_nxt  = in_bitstream_2;
          pw2_nxt = (flag == FLAG_TWO);
          pfl_nxt = flag_final_bits;
          if (flag == FLAG_BAD) err_nxt = 1'b1;
          if (flag[0]) take = 1'b1;
          else advance = 1'b1;
        end
      end
      PROC2: begin
        pw2_nxt = 1'b0;
        take = 1'b1;
      end
      EMIT_HOLD, EMIT_RUN: begin
        if (out_ready) begin
          if (|cnt_q) begin
            ob_nxt = fill_q;
            cnt_nxt = cnt_q - 1'b1;
            state_nxt = EMIT_RUN;
          end else begin
            advance = 1'b1;
          end
        end
      end
      FLUSH_HOLD, FLUSH_RUN: begin
        if (out_ready) begin
          if (|cnt_q) begin
            ob_nxt = fill_q;
            cnt_nxt = cnt_q - 1'b1;
            last_nxt = (cnt_q == RW'(1));
            state_nxt = FLUSH_RUN;
          end else begin
            hold_nxt = '0;
            hv_nxt = 1'b0;
            run_nxt = '0;
            last_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) begin
      hold_nxt = res.h;
      hv_nxt = res.hv;
      run_nxt = res.r;
      if (res.err) err_nxt = 1'b1;
      if (res.emit) begin
        state_nxt = EMIT_HOLD;
        ob_nxt = res.e;
        cnt_nxt = res.n;
        fill_nxt = res.fill;
        last_nxt = 1'b0;
      end else begin
        advance = 1'b1;
      end
    end
    if (advance) begin
      if (pw2_nxt) begin
        state_nxt = PROC2;
      end else if (pfl_nxt) begin
        pfl_nxt = 1'b0;
        ob_nxt = hold_nxt;
        cnt_nxt = run_nxt;
        fill_nxt = '1;
        last_nxt = hv_nxt && !(|run_nxt);
        state_nxt = hv_nxt ? FLUSH_HOLD : IDLE;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hold_q  <= '0;
      hv_q    <= 1'b0;
      run_q   <= '0;
      cnt_q   <= '0;
      ob_q    <= '0;
      fill_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      w2_q    <= '0;
      pw2_q   <= 1'b0;
      pfl_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      hold_q  <= hold_nxt;
      hv_q    <= hv_nxt;
      run_q   <= run_nxt;
      cnt_q   <= cnt_nxt;
      ob_q    <= ob_nxt;
      fill_q  <= fill_nxt;
      last_q  <= last_nxt;
      err_q   <= err_nxt;
      w2_q    <= w2_nxt;
      pw2_q   <= pw2_nxt;
      pfl_q   <= pfl_nxt;
      armed_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_4_carry_resolver.sv
// Directed-vector bench for the carry resolver stage.
// Collects output bytes and compares against hand-derived lists.
module tb_stage_4_carry_resolver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  flag = 2'b00;
  logic        fin = 1'b0;
  logic [15:0] w1 = '0;
  logic [15:0] w2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        error;

  int checks = 0;
  int failures = 0;

  logic       tog_mode = 1'b0;
  logic       want_rdy = 1'b1;
  logic [7:0] got_b[$];
  logic       got_l[$];
  logic [7:0] exp_b[$];
  logic       stall_seen = 1'b0;
  logic [8:0] stall_val = '0;

  stage_4_carry_resolver dut (
    .clk(clk),
    .reset(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flag(flag),
    .flag_final_bits(fin),
    .in_bitstream_1(w1),
    .in_bitstream_2(w2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte(out_byte),
    .out_last(out_last),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = tog_mode ? ~out_ready : want_rdy;
  end

  always @(negedge clk) begin
    if (rst_n && stall_seen)
      chk("stall_hold", {23'd0, out_last, out_byte},
          {23'd0, stall_val});
    stall_seen = rst_n && out_valid && !out_ready;
    stall_val = {out_last, out_byte};
    if (rst_n && out_valid && out_ready) begin
      got_b.push_back(out_byte);
      got_l.push_back(out_last);
    end
  end

  task automatic send(input logic [1:0] f,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic fl);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("send_timeout", 0, 1);
    flag = f;
    w1 = a;
    w2 = b;
    fin = fl;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag,
                            input logic has_last);
    int t = 0;
    int n;
    n = exp_b.size();
    while (got_b.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    chk({tag, "_count"}, got_b.size(), n);
    for (int i = 0; i < n && i < got_b.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), got_b[i], exp_b[i]);
      chk($sformatf("%s_l%0d", tag, i), got_l[i],
          has_last && (i == n - 1));
    end
    got_b.delete();
    got_l.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got_b.delete();
    got_l.delete();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_error", error, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    send(2'b01, 16'h0040, 16'h0, 1'b0);
    send(2'b01, 16'h00FF, 16'h0, 1'b0);
    send(2'b01, 16'h012C, 16'h0, 1'b1);
    exp_b = '{8'h41, 8'h00, 8'h2C};
    expect_out("c1", 1'b1);
    chk("c1_error", error, 0);

    send(2'b01, 16'h0010, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++)
      send(2'b01, 16'h00FF, 16'h0, 1'b0);
    send(2'b01, 16'h0105, 16'h0, 1'b1);
    exp_b = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h05};
    expect_out("c2", 1'b1);
    chk("c2_error", error, 0);

    send(2'b01, 16'h0020, 16'h0, 1'b0);
    send(2'b01, 16'h00FF, 16'h0, 1'b0);
    send(2'b01, 16'h00FF, 16'h0, 1'b0);
    send(2'b01, 16'h0030, 16'h0, 1'b1);
    exp_b = '{8'h20, 8'hFF, 8'hFF, 8'h30};
    expect_out("c3", 1'b1);
    chk("c3_error", error, 0);

    tog_mode = 1'b1;
    send(2'b11, 16'h0050, 16'h01FF, 1'b0);
    send(2'b01, 16'h0001, 16'h0, 1'b1);
    exp_b = '{8'h51, 8'hFF, 8'h01};
    expect_out("c4", 1'b1);
    chk("c4_error", error, 0);
    tog_mode = 1'b0;

    do_reset();
    send(2'b01, 16'h0100, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("c5_first_carry_err", error, 1);

    do_reset();
    send(2'b01, 16'h0005, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("c5_no_err", error, 0);
    send(2'b01, 16'h0201, 16'h0, 1'b1);
    exp_b = '{8'h06, 8'h01};
    expect_out("c5", 1'b1);
    chk("c5_big_carry_err", error, 1);

    do_reset();
    send(2'b01, 16'h0077, 16'h0, 1'b0);
    send(2'b00, 16'h0, 16'h0, 1'b1);
    exp_b = '{8'h77};
    expect_out("c6", 1'b1);
    chk("c6_error", error, 0);
    send(2'b10, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("c6_bad_flag_err", error, 1);

    do_reset();
    want_rdy = 1'b0;
    send(2'b01, 16'h0010, 16'h0, 1'b0);
    send(2'b01, 16'h00FF, 16'h0, 1'b0);
    send(2'b01, 16'h00FF, 16'h0, 1'b0);
    send(2'b01, 16'h0033, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("c7_stalled_valid", out_valid, 1);
    chk("c7_stalled_byte", out_byte, 8'h10);
    want_rdy = 1'b1;
    @(posedge clk);
    #2 want_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("c7_run_byte", out_byte, 8'hFF);
    #1 rst_n = 1'b0;
    #1;
    chk("c7_rst_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    want_rdy = 1'b1;
    @(negedge clk);
    chk("c7_in_ready", in_ready, 1);
    repeat (6) @(negedge clk);
    chk("c7_count", got_b.size(), 1);
    chk("c7_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
